// File: rtl/car_pkg.sv
// car_pkg
// Shared definitions for the car controller: track codes produced by the
// button-driven selector, the start-sequencer FSM encoding and the upper
// bound on the start countdown length.
package car_pkg;

    typedef logic [1:0] circuit_t;

    // Track codes as presented by the selector.
    localparam circuit_t CIRC_NONE      = 2'd0;
    localparam circuit_t CIRC_LINIE     = 2'd1;
    localparam circuit_t CIRC_CURBE     = 2'd2;
    localparam circuit_t CIRC_ANDURANTA = 2'd3;

    // Start-sequencer FSM encoding; 2'b11 is unused and recovers to IDLE.
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ARMING = 2'b01;
    localparam logic [1:0] ST_RUN    = 2'b10;

    // Countdown register is 3 bits wide, so 7 s is the longest start delay.
    localparam int SEQ_MAX_COUNT_S = 7;

    // True when the selector presents an actual track.
    function automatic logic is_track(input circuit_t code);
        return code != CIRC_NONE;
    endfunction

endpackage

// File: rtl/second_prescaler.sv
// second_prescaler
// Divides the system clock down to a one-cycle tick every CLK_HZ enabled
// cycles (a 1 Hz base at the nominal clock).
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-high reset
//   clear  in   synchronous restart of the count from 0 (wins over enable)
//   enable in   count advances only while high
//   tick   out  high during the cycle the count sits at CLK_HZ-1 while enabled
module second_prescaler #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    generate
        if (CLK_HZ < 1) begin : g_bad_clk_hz
            $error("second_prescaler: CLK_HZ must be at least 1");
        end
    endgenerate

    // A 1 Hz clock would give a zero-width counter; keep at least one bit.
    localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [W-1:0] TERMINAL = W'(CLK_HZ - 1);

    logic [W-1:0] count;

    // The consumer registers the tick, so flagging the terminal count here
    // lands its decrement exactly CLK_HZ cycles after the last clear.
    assign tick = enable && !clear && (count == TERMINAL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == TERMINAL) begin
                count <= '0;
            end else begin
                count <= count + W'(1);
            end
        end
    end

endmodule

// File: rtl/start_sequencer.sv
// start_sequencer
// Takes the track selection from the button-driven selector, brings it into
// the clk domain, waits COUNT_S seconds once a valid track is selected and
// then commands the drive logic to move with the latched track code.
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous, active-high reset
//   circuit        in   track code from the selector (async to clk)
//   reset_counter  in   selector abort, 1 = no track (async to clk)
//   run            out  move command
//   active_circuit out  track code latched at ARMING entry, 0 in IDLE
//   arming         out  countdown in progress
//   countdown      out  whole seconds remaining, 0 outside ARMING
//   sec_tick       out  one-cycle pulse on every countdown decrement
//
// FSM:
//   state  | meaning
//   IDLE   | no valid track; all outputs low
//   ARMING | counting down from COUNT_S with the latched track
//   RUN    | countdown expired; run asserted with the latched track
module start_sequencer
    import car_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int COUNT_S = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] circuit,
    input  logic       reset_counter,
    output logic       run,
    output logic [1:0] active_circuit,
    output logic       arming,
    output logic [2:0] countdown,
    output logic       sec_tick
);

    generate
        if (COUNT_S < 1 || COUNT_S > SEQ_MAX_COUNT_S) begin : g_bad_count_s
            $error("start_sequencer: COUNT_S must be in 1..7");
        end
    endgenerate

    localparam logic [2:0] COUNT_INIT = 3'(COUNT_S);

    logic [1:0] state;

    // Two-flop synchronizers; reset values are the selector's idle outputs
    // so a reset never looks like a fresh selection.
    circuit_t   circuit_m;
    circuit_t   circuit_s;
    logic       rc_m;
    logic       rc_s;

    logic       abort;
    logic       changed;
    logic       presc_clear;
    logic       presc_enable;
    logic       presc_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            circuit_m <= CIRC_NONE;
            circuit_s <= CIRC_NONE;
            rc_m      <= 1'b1;
            rc_s      <= 1'b1;
        end else begin
            circuit_m <= circuit;
            circuit_s <= circuit_m;
            rc_m      <= reset_counter;
            rc_s      <= rc_m;
        end
    end

    assign abort   = rc_s || !is_track(circuit_s);
    // Only meaningful when abort is low, i.e. circuit_s is a real track.
    assign changed = (circuit_s != active_circuit);

    // Outside ARMING the prescaler is held at 0 so every entry or reload
    // starts a full second.
    assign presc_enable = (state == ST_ARMING);
    assign presc_clear  = (state != ST_ARMING) || abort || changed;

    second_prescaler #(
        .CLK_HZ(CLK_HZ)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (presc_clear),
        .enable (presc_enable),
        .tick   (presc_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            run            <= 1'b0;
            arming         <= 1'b0;
            countdown      <= '0;
            active_circuit <= CIRC_NONE;
            sec_tick       <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!abort) begin
                        state          <= ST_ARMING;
                        arming         <= 1'b1;
                        run            <= 1'b0;
                        countdown      <= COUNT_INIT;
                        active_circuit <= circuit_s;
                    end
                end

                ST_ARMING, ST_RUN: begin
                    if (abort) begin
                        // Beats a coincident terminal tick: run never pulses.
                        state          <= ST_IDLE;
                        run            <= 1'b0;
                        arming         <= 1'b0;
                        countdown      <= '0;
                        active_circuit <= CIRC_NONE;
                    end else if (changed) begin
                        state          <= ST_ARMING;
                        run            <= 1'b0;
                        arming         <= 1'b1;
                        countdown      <= COUNT_INIT;
                        active_circuit <= circuit_s;
                    end else if (state == ST_ARMING && presc_tick) begin
                        sec_tick <= 1'b1;
                        if (countdown <= 3'd1) begin
                            state     <= ST_RUN;
                            run       <= 1'b1;
                            arming    <= 1'b0;
                            countdown <= '0;
                        end else begin
                            countdown <= countdown - 3'd1;
                        end
                    end
                end

                default: begin
                    state          <= ST_IDLE;
                    run            <= 1'b0;
                    arming         <= 1'b0;
                    countdown      <= '0;
                    active_circuit <= CIRC_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_start_sequencer.sv
module tb_start_sequencer;

    localparam int CLK_HZ  = 10;
    localparam int COUNT_S = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] circuit;
    logic       reset_counter;
    logic       run;
    logic [1:0] active_circuit;
    logic       arming;
    logic [2:0] countdown;
    logic       sec_tick;

    int checks = 0;
    int errors = 0;

    start_sequencer #(
        .CLK_HZ (CLK_HZ),
        .COUNT_S(COUNT_S)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .circuit       (circuit),
        .reset_counter (reset_counter),
        .run           (run),
        .active_circuit(active_circuit),
        .arming        (arming),
        .countdown     (countdown),
        .sec_tick      (sec_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] circ;
        logic       rc;
        int         cycles;
        logic       run;
        logic       arm;
        logic [2:0] cd;
        logic [1:0] act;
        logic       tick;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] circ, input logic rc, input int cycles,
                                input logic r, input logic a, input logic [2:0] cd,
                                input logic [1:0] act, input logic tick);
        vec_t v;
        v.circ = circ; v.rc = rc; v.cycles = cycles;
        v.run = r; v.arm = a; v.cd = cd; v.act = act; v.tick = tick;
        return v;
    endfunction

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic r, input logic a,
                         input logic [2:0] cd, input logic [1:0] act, input logic tick);
        logic [8:0] got;
        logic [8:0] exp;
        got = {run, arming, countdown, active_circuit, sec_tick};
        exp = {r, a, cd, act, tick};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got run=%b arming=%b countdown=%0d active=%0d tick=%b, want run=%b arming=%b countdown=%0d active=%0d tick=%b",
                     name, run, arming, countdown, active_circuit, sec_tick, r, a, cd, act, tick);
        end
    endtask

    initial begin
        // Nominal select of curves, count down, run.
        vecs.push_back(mk(2'd0, 1'b1, 2,  0, 0, 3'd0, 2'd0, 0));
        vecs.push_back(mk(2'd2, 1'b0, 2,  0, 0, 3'd0, 2'd0, 0));
        vecs.push_back(mk(2'd2, 1'b0, 1,  0, 1, 3'd5, 2'd2, 0));
        vecs.push_back(mk(2'd2, 1'b0, 9,  0, 1, 3'd5, 2'd2, 0));
        vecs.push_back(mk(2'd2, 1'b0, 1,  0, 1, 3'd4, 2'd2, 1));
        vecs.push_back(mk(2'd2, 1'b0, 1,  0, 1, 3'd4, 2'd2, 0));
        vecs.push_back(mk(2'd2, 1'b0, 9,  0, 1, 3'd3, 2'd2, 1));
        vecs.push_back(mk(2'd2, 1'b0, 10, 0, 1, 3'd2, 2'd2, 1));
        vecs.push_back(mk(2'd2, 1'b0, 10, 0, 1, 3'd1, 2'd2, 1));
        vecs.push_back(mk(2'd2, 1'b0, 9,  0, 1, 3'd1, 2'd2, 0));
        vecs.push_back(mk(2'd2, 1'b0, 1,  1, 0, 3'd0, 2'd2, 1));
        vecs.push_back(mk(2'd2, 1'b0, 20, 1, 0, 3'd0, 2'd2, 0));
        // Abort in RUN.
        vecs.push_back(mk(2'd0, 1'b1, 2,  1, 0, 3'd0, 2'd2, 0));
        vecs.push_back(mk(2'd0, 1'b1, 1,  0, 0, 3'd0, 2'd0, 0));
        // Track change while running.
        vecs.push_back(mk(2'd1, 1'b0, 3,  0, 1, 3'd5, 2'd1, 0));
        vecs.push_back(mk(2'd1, 1'b0, 50, 1, 0, 3'd0, 2'd1, 1));
        vecs.push_back(mk(2'd2, 1'b0, 2,  1, 0, 3'd0, 2'd1, 0));
        vecs.push_back(mk(2'd2, 1'b0, 1,  0, 1, 3'd5, 2'd2, 0));
        vecs.push_back(mk(2'd2, 1'b0, 50, 1, 0, 3'd0, 2'd2, 1));
        // Re-select during ARMING at countdown 2.
        vecs.push_back(mk(2'd0, 1'b1, 3,  0, 0, 3'd0, 2'd0, 0));
        vecs.push_back(mk(2'd1, 1'b0, 3,  0, 1, 3'd5, 2'd1, 0));
        vecs.push_back(mk(2'd1, 1'b0, 30, 0, 1, 3'd2, 2'd1, 1));
        vecs.push_back(mk(2'd3, 1'b0, 2,  0, 1, 3'd2, 2'd1, 0));
        vecs.push_back(mk(2'd3, 1'b0, 1,  0, 1, 3'd5, 2'd3, 0));
        vecs.push_back(mk(2'd3, 1'b0, 49, 0, 1, 3'd1, 2'd3, 0));
        vecs.push_back(mk(2'd3, 1'b0, 1,  1, 0, 3'd0, 2'd3, 1));
        // reset_counter alone aborts; circuit 0 alone never arms.
        vecs.push_back(mk(2'd3, 1'b1, 3,  0, 0, 3'd0, 2'd0, 0));
        vecs.push_back(mk(2'd0, 1'b0, 5,  0, 0, 3'd0, 2'd0, 0));

        reset         = 1'b1;
        circuit       = 2'd0;
        reset_counter = 1'b1;
        step(2);
        check("reset_state", 0, 0, 3'd0, 2'd0, 0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            circuit       = vecs[i].circ;
            reset_counter = vecs[i].rc;
            step(vecs[i].cycles);
            check($sformatf("vec%0d", i), vecs[i].run, vecs[i].arm, vecs[i].cd,
                  vecs[i].act, vecs[i].tick);
        end

        // Async reset mid-ARMING at countdown 3, then restart from COUNT_S.
        circuit       = 2'd1;
        reset_counter = 1'b0;
        step(3);
        check("rst_entry", 0, 1, 3'd5, 2'd1, 0);
        step(20);
        check("rst_cd3", 0, 1, 3'd3, 2'd1, 1);
        #2 reset = 1'b1;
        #1;
        check("rst_async_clear", 0, 0, 3'd0, 2'd0, 0);
        step(2);
        #2 reset = 1'b0;
        step(2);
        check("rst_release_sync", 0, 0, 3'd0, 2'd0, 0);
        step(1);
        check("rst_rearm", 0, 1, 3'd5, 2'd1, 0);

        // Abort reaching rc_s on the same edge as the final tick.
        circuit       = 2'd0;
        reset_counter = 1'b1;
        step(3);
        check("sim_idle", 0, 0, 3'd0, 2'd0, 0);
        circuit       = 2'd2;
        reset_counter = 1'b0;
        step(3);
        check("sim_entry", 0, 1, 3'd5, 2'd2, 0);
        step(47);
        reset_counter = 1'b1;
        step(2);
        check("sim_last_arm", 0, 1, 3'd1, 2'd2, 0);
        step(1);
        check("sim_abort_wins", 0, 0, 3'd0, 2'd0, 0);
        step(12);
        check("sim_stays_idle", 0, 0, 3'd0, 2'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Run must never pulse during the simultaneous-abort window.
    logic watch_run = 1'b0;
    initial begin
        wait (checks > 0);
        forever begin
            @(negedge clk);
            if (watch_run && run) begin
                checks++;
                errors++;
                $display("FAIL sim_run_pulse: got run=1, want run=0");
            end
        end
    end
    initial begin
        wait (checks >= 36);
        watch_run = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

endmodule
